rx_frame_ctrl: RTL

//  UART receive frame controller; sits directly upstream of the RX shift register (SIPO).

---
 rtl/rx_frame_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl -- UART receive frame controller feeding an RX SIPO.
//
// Synchronises the raw rx line, detects a start bit on the oversampled baud
// tick, majority-votes every bit around mid-period and hands each data bit to
// the SIPO as a one-clock enable. Optional parity and the stop bit are checked
// at the end of the frame.
//
// Ports:
//   clk             system clock, rising edge
//   rx_rst          synchronous active-high reset
//   baud_tick       1-clk pulse, OVERSAMPLE per bit period
//   rx              raw serial line, idle high, asynchronous to clk
//   fsm_enable_sipo 1-clk pulse per data bit
//   rx_bit          voted bit value, valid while fsm_enable_sipo=1
//   sipo_rst        1-clk pulse on start-bit acceptance
//   rx_done         1-clk pulse at the stop-bit decision
//   parity_err      parity mismatch of last frame, valid from rx_done
//   frame_err       stop bit sampled low in last frame, valid from rx_done
//   busy            high in every state except IDLE
//
// All pulse outputs and error flags are registered, so they appear one clock
// after the baud tick on which the decision is made.
module rx_frame_ctrl #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rx_rst,
  input  logic baud_tick,
  input  logic rx,
  output logic fsm_enable_sipo,
  output logic rx_bit,
  output logic sipo_rst,
  output logic rx_done,
  output logic parity_err,
  output logic frame_err,
  output logic busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned H  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_PRE  = TW'(H - 1);
  localparam logic [TW-1:0] T_MID  = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic PAR_INIT = (PARITY_ODD != 0);
  localparam logic HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic          par, par_n;
  logic          armed, armed_n;
  logic          s0, s0_n, s1, s1_n;
  logic          rx_meta, rx_s;
  logic          vote;
  logic          en_n, bit_o_n, srst_n, done_n, perr_n, ferr_n;
  logic          dec_tick, last_tick;

  // Two-flop synchroniser, idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Third capture is rx_s itself on the decision tick.
  always_comb begin
    vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    dec_tick  = (tick_cnt == T_DEC);
    last_tick = (tick_cnt == T_LAST);
  end

  always_ff @(posedge clk) begin
    if (rx_rst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      par             <= 1'b0;
      armed           <= 1'b0;
      s0              <= 1'b0;
      s1              <= 1'b0;
      fsm_enable_sipo <= 1'b0;
      rx_bit          <= 1'b1;
      sipo_rst        <= 1'b0;
      rx_done         <= 1'b0;
      parity_err      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      state           <= state_n;
      tick_cnt        <= tick_n;
      bit_cnt         <= bit_n;
      par             <= par_n;
      armed           <= armed_n;
      s0              <= s0_n;
      s1              <= s1_n;
      fsm_enable_sipo <= en_n;
      rx_bit          <= bit_o_n;
      sipo_rst        <= srst_n;
      rx_done         <= done_n;
      parity_err      <= perr_n;
      frame_err       <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    par_n   = par;
    armed_n = armed;
    s0_n    = s0;
    s1_n    = s1;
    en_n    = 1'b0;
    bit_o_n = rx_bit;
    srst_n  = 1'b0;
    done_n  = 1'b0;
    perr_n  = parity_err;
    ferr_n  = frame_err;

    if (baud_tick) begin
      if (state != IDLE) begin
        tick_n = last_tick ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_PRE) s0_n = rx_s;
        if (tick_cnt == T_MID) s1_n = rx_s;
      end

      case (state)
        IDLE: begin
          // The detecting tick counts as tick 0 of the start bit.
          if (armed && !rx_s) begin
            state_n = START;
            tick_n  = TW'(1);
            srst_n  = 1'b1;
          end else if (rx_s) begin
            armed_n = 1'b1;
          end
        end

        START: begin
          if (dec_tick && vote) begin
            state_n = IDLE;
            armed_n = 1'b1;
            tick_n  = '0;
          end else if (last_tick) begin
            state_n = DATA;
            bit_n   = '0;
            par_n   = PAR_INIT;
          end
        end

        DATA: begin
          if (dec_tick) begin
            en_n    = 1'b1;
            bit_o_n = vote;
            par_n   = par ^ vote;
          end
          if (last_tick) begin
            bit_n = bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) state_n = HAS_PAR ? PARITY : STOP;
          end
        end

        PARITY: begin
          if (dec_tick) par_n = par ^ vote;
          if (last_tick) state_n = STOP;
        end

        STOP: begin
          // Leave at the decision tick so back-to-back frames have slack
          // to find the next start edge.
          if (dec_tick) begin
            done_n  = 1'b1;
            ferr_n  = ~vote;
            perr_n  = HAS_PAR ? par : 1'b0;
            armed_n = vote;
            state_n = IDLE;
            tick_n  = '0;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
